display_owner_arbiter: RTL and testbench
========================================

// Module: display_owner_arbiter
// PURPOSE
//  Shares the rover's 4-digit seven-segment display among N_REQ message sources
//  (frequency search result, motor status, fault code, ...).
//  - Picks one owner by fixed priority and enforces a minimum on-screen hold time.
//  - Drives the registered 4-nibble word consumed by the seven-segment driver.
//  - Sits between the control FSMs and the display driver.
// PARAMETERS
//  N_REQ       3       number of requesters; index 0 = highest priority
//  TICK_DIV    100000  clock cycles per hold tick (1 ms at 100 MHz)
//  HOLD_TICKS  500     minimum ticks an owner keeps the display once granted
//  DASH        4'hC    nibble code the driver renders as '-'
// PORTS
//  clock    in   1         system clock, rising edge
//  reset_n  in   1         asynchronous active-low reset
//  req      in   N_REQ     per-source display request, level
//  value    in   16*N_REQ  per-source digits; source i at [16i+15:16i], nibble 3 = leftmost
//  grant    out  N_REQ     one-hot owner of the display; 0 when idle
//  digits   out  16        4 nibbles to the display driver
//  busy     out  1         1 while any source owns the display
// BEHAVIOUR
//  Reset, asynchronous:
//  - grant=0, digits={4{DASH}}, busy=0, state=IDLE.
//  - Prescaler and hold counter cleared.
//  - Reset mid-hold drops ownership immediately; nothing is restored after reset.
//  Prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle at the wrap. It runs freely.
//  States:
//  - IDLE: grant=0, digits={4{DASH}}. If req!=0, grant the lowest set index on the next edge,
//    load digits from that value, load hold=HOLD_TICKS, go to HOLD. Latency req->grant is 1 cycle.
//  - HOLD: digits <= owner value every cycle (1-cycle registered latency).
//    - hold decrements on tick; at hold==0 go to OWN.
//    - If the owner drops req during HOLD, grant stays set and digits freeze at the last value
//      sampled while req was high, until the hold expires.
//    - Higher-priority requests wait; no preemption during HOLD.
//  - OWN: digits track the owner value every cycle. Evaluate each cycle:
//    a) Any req at an index < owner: switch grant to the lowest such index, reload digits
//       and hold, go to HOLD. Preemption is 1 cycle.
//    b) Owner req low: if other req pending, grant the lowest remaining index (->HOLD),
//       otherwise -> IDLE. No idle gap cycle between owners.
//    c) Otherwise keep the owner.
//  - HOLD expiry with the owner req already low: apply the OWN rules in the same cycle.
//  Boundaries and widths:
//  - grant is always one-hot or zero; busy = |grant.
//  - Owner release and a new req in the same cycle: the new req is eligible.
//  - hold counter width is $clog2(HOLD_TICKS+1). HOLD_TICKS=0 means HOLD lasts 1 cycle.
//  - Nibbles >9 pass through unchanged; the driver renders them.
//  - Unused state encodings recover to IDLE.
// STRUCTURE
//  - display_pkg: DASH_CODE, BLANK_WORD={4{DASH_CODE}}, state enum {IDLE,HOLD,OWN}.
//  - Sub-module tick_prescaler (clock, reset_n, tick); parameter TICK_DIV.
//  - Priority pick and state FSM are inline.
// TESTING  (bench uses TICK_DIV=4, HOLD_TICKS=3, N_REQ=3)
//  1 Reset: reset_n=0 mid-run -> grant=000, digits=16'hCCCC, busy=0, all asynchronously.
//  2 Idle grant: req=010, value1=16'h0090 -> next edge grant=010, digits=16'h0090.
//    After 12 cycles the FSM is in OWN.
//  3 Hold, no preempt: owner 2 in HOLD, req0 rises -> grant stays 100 until hold expires.
//    Then grant=001 within 1 cycle.
//  4 Preempt in OWN: owner 1, req0 rises -> grant=001 next edge, digits=value0.
//  5 Release handoff: owner 0 drops req with req2 high -> grant=100 next edge, no 000 cycle.
//    Sole owner drops -> IDLE, digits=16'hCCCC.
//  6 Drop in HOLD: owner drops req at tick 1 -> digits frozen, grant held until expiry.
//    Then grant=000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the seven-segment display owner arbiter.
package display_pkg;

    localparam logic [3:0]  DASH_CODE  = 4'hC;
    localparam logic [15:0] BLANK_WORD = {4{DASH_CODE}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OWN  = 2'd2
    } state_t;

endpackage

// File: rtl/display_owner_arbiter_tick_prescaler.sv
// Free-running prescaler: one-cycle tick each time the count wraps at TICK_DIV-1.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Wrap counter; the tick is registered so it leaves this block glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_tick <= (r_cnt == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/display_owner_arbiter.sv
// Fixed-priority owner of the 4-digit display with a minimum on-screen hold time.
module display_owner_arbiter
    import display_pkg::*;
#(
    parameter int         N_REQ      = 3,
    parameter int         TICK_DIV   = 100000,
    parameter int         HOLD_TICKS = 500,
    parameter logic [3:0] DASH       = DASH_CODE
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  value,
    output logic [N_REQ-1:0]     grant,
    output logic [15:0]          digits,
    output logic                 busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [15:0]   BLANK  = {4{DASH}};
    localparam logic [HW-1:0] HOLD_N = HW'(HOLD_TICKS);

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IW-1:0]    r_owner;
    logic [HW-1:0]    r_hold;
    logic [15:0]      r_digits;
    logic             r_busy;

    logic             w_tick;
    logic             w_any;
    logic [IW-1:0]    w_pick;
    logic [15:0]      w_pick_val;
    logic [15:0]      w_own_val;
    logic             w_own_req;

    state_t           w_ow_state;
    logic [N_REQ-1:0] w_ow_grant;
    logic [IW-1:0]    w_ow_owner;
    logic [HW-1:0]    w_ow_hold;
    logic [15:0]      w_ow_digits;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // Lowest set request index wins; index 0 is the highest priority.
    always_comb begin
        w_any  = |req;
        w_pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick = IW'(i);
            end else begin
                w_pick = w_pick;
            end
        end
        w_pick_val = value[16*w_pick +: 16];
        w_own_val  = value[16*r_owner +: 16];
        w_own_req  = req[r_owner];
    end

    // Ownership decision once the hold has expired. Because the owner's own
    // request would make it the lowest index unless a higher-priority source
    // is up, "pick differs from owner" covers both preemption and handoff.
    always_comb begin
        w_ow_state  = OWN;
        w_ow_grant  = r_grant;
        w_ow_owner  = r_owner;
        w_ow_hold   = r_hold;
        w_ow_digits = w_own_val;
        if (!w_any) begin
            w_ow_state  = IDLE;
            w_ow_grant  = '0;
            w_ow_owner  = '0;
            w_ow_digits = BLANK;
        end else if (w_pick != r_owner) begin
            w_ow_state  = HOLD;
            w_ow_grant  = N_REQ'(1'b1) << w_pick;
            w_ow_owner  = w_pick;
            w_ow_hold   = HOLD_N;
            w_ow_digits = w_pick_val;
        end else begin
            w_ow_state  = OWN;
            w_ow_digits = w_own_val;
        end
    end

    // Owner FSM with registered grant, digits and busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_hold   <= '0;
            r_digits <= BLANK;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= HOLD;
                        r_grant  <= N_REQ'(1'b1) << w_pick;
                        r_owner  <= w_pick;
                        r_hold   <= HOLD_N;
                        r_digits <= w_pick_val;
                        r_busy   <= 1'b1;
                    end else begin
                        r_grant  <= '0;
                        r_digits <= BLANK;
                        r_busy   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        if (w_own_req) begin
                            r_state  <= OWN;
                            r_digits <= w_own_val;
                        end else begin
                            r_state  <= w_ow_state;
                            r_grant  <= w_ow_grant;
                            r_owner  <= w_ow_owner;
                            r_hold   <= w_ow_hold;
                            r_digits <= w_ow_digits;
                            r_busy   <= w_any;
                        end
                    end else begin
                        // A dropped owner keeps its last sampled digits until expiry.
                        if (w_own_req) begin
                            r_digits <= w_own_val;
                        end else begin
                            r_digits <= r_digits;
                        end
                        if (w_tick) begin
                            r_hold <= r_hold - HW'(1);
                        end else begin
                            r_hold <= r_hold;
                        end
                    end
                end
                OWN: begin
                    r_state  <= w_ow_state;
                    r_grant  <= w_ow_grant;
                    r_owner  <= w_ow_owner;
                    r_hold   <= w_ow_hold;
                    r_digits <= w_ow_digits;
                    r_busy   <= w_any;
                end
                default: begin
                    r_state  <= IDLE;
                    r_grant  <= '0;
                    r_owner  <= '0;
                    r_hold   <= '0;
                    r_digits <= BLANK;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign digits = r_digits;
    assign busy   = r_busy;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Directed and randomized checks of the display owner arbiter against a priority/hold model.
module tb_display_owner_arbiter;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int HT = 3;
    localparam logic [15:0] BLANK = 16'hCCCC;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic [N-1:0]  req     = '0;
    logic [16*N-1:0] value = '0;
    logic [N-1:0]  grant;
    logic [15:0]   digits;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the display, how many ticks of guaranteed hold remain
    // (-1 once the guarantee is over), what is shown, and edges since reset.
    int          m_owner   = -1;
    int          m_hold    = -1;
    logic [15:0] m_digits  = BLANK;
    int          m_edges   = 0;

    display_owner_arbiter #(
        .N_REQ      (N),
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT),
        .DASH       (4'hC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .value   (value),
        .grant   (grant),
        .digits  (digits),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_req(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] src_val(input int i);
        return value[16*i +: 16];
    endfunction

    task automatic take(input int i);
        m_owner  = i;
        m_hold   = HT;
        m_digits = src_val(i);
    endtask

    task automatic after_hold_rules(input int lo);
        if (lo >= 0 && lo < m_owner) begin
            take(lo);
        end else if (!req[m_owner]) begin
            if (lo >= 0) begin
                take(lo);
            end else begin
                m_owner  = -1;
                m_hold   = -1;
                m_digits = BLANK;
            end
        end else begin
            m_digits = src_val(m_owner);
        end
    endtask

    task automatic model_edge();
        bit tick;
        int lo;
        tick = (m_edges > 0) && (m_edges % TD == 0);
        m_edges++;
        lo = lowest_req(req);
        if (m_owner < 0) begin
            if (lo >= 0) take(lo);
            else m_digits = BLANK;
        end else if (m_hold >= 0) begin
            if (m_hold == 0) begin
                if (req[m_owner]) begin
                    m_hold   = -1;
                    m_digits = src_val(m_owner);
                end else begin
                    after_hold_rules(lo);
                end
            end else begin
                if (req[m_owner]) m_digits = src_val(m_owner);
                if (tick) m_hold--;
            end
        end else begin
            after_hold_rules(lo);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        chk("grant",  {13'd0, grant}, {13'd0, g});
        chk("digits", digits, m_digits);
        chk("busy",   {15'd0, busy}, {15'd0, (m_owner >= 0)});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_hold   = -1;
        m_digits = BLANK;
        m_edges  = 0;
    endtask

    initial begin
        logic [15:0] v0;

        // Reset state, applied asynchronously before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("rst_grant",  {13'd0, grant}, 16'h0000);
        chk("rst_digits", digits, BLANK);
        chk("rst_busy",   {15'd0, busy}, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        step_n(3);

        // Idle grant to source 1.
        value[31:16] = 16'h0090;
        req = 3'b010;
        step();
        chk("idle_grant",  {13'd0, grant}, 16'h0002);
        chk("idle_digits", digits, 16'h0090);
        step_n(12);

        // Hold without preemption, then handover to source 0.
        req = 3'b000;
        step_n(4);
        value[47:32] = 16'hA2B3;
        value[15:0]  = 16'h0001;
        req = 3'b100;
        step();
        chk("hold_grant", {13'd0, grant}, 16'h0004);
        req = 3'b101;
        step();
        chk("no_preempt", {13'd0, grant}, 16'h0004);
        step_n(16);
        chk("after_hold", {13'd0, grant}, 16'h0001);

        // Preemption while source 1 owns the display outside its hold.
        req = 3'b000;
        step_n(16);
        req = 3'b010;
        step_n(16);
        v0 = 16'h7F3E;
        value[15:0] = v0;
        req = 3'b011;
        step();
        chk("preempt_grant",  {13'd0, grant}, 16'h0001);
        chk("preempt_digits", digits, v0);

        // Release handoff to source 2, then sole owner release to idle.
        step_n(16);
        req = 3'b100;
        step();
        chk("handoff_grant", {13'd0, grant}, 16'h0004);
        step_n(16);
        req = 3'b000;
        step();
        chk("release_grant",  {13'd0, grant}, 16'h0000);
        chk("release_digits", digits, BLANK);

        // Owner drops during hold: digits freeze, grant held to expiry.
        step_n(2);
        value[31:16] = 16'h1234;
        req = 3'b010;
        step_n(5);
        value[31:16] = 16'h5678;
        req = 3'b000;
        step();
        chk("freeze_digits", digits, 16'h1234);
        chk("freeze_grant",  {13'd0, grant}, 16'h0002);
        step_n(16);
        chk("drop_expiry", {13'd0, grant}, 16'h0000);

        // Asynchronous reset in the middle of a hold.
        req = 3'b001;
        step_n(3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant",  {13'd0, grant}, 16'h0000);
        chk("mid_rst_digits", digits, BLANK);
        chk("mid_rst_busy",   {15'd0, busy}, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        step_n(3);

        // Randomized traffic with slowly changing requests and values.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, N - 1);
                req[b] = ~req[b];
            end
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                value[16*s +: 16] = 16'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
